// File: rtl/wb_drp_mux.sv
// Wishbone-to-DRP bridge. It routes one Wishbone slave onto PORTS DRP ports.
// The port is chosen by the upper address bits. A response timeout covers
// ports that never assert ready. All outputs are registered.
module wb_drp_mux #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PORTS      = 4,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  // Wishbone slave side
  input  logic [ADDR_WIDTH+SEL_WIDTH-1:0]  wb_adr_i,
  input  logic [15:0]                      wb_dat_i,
  output logic [15:0]                      wb_dat_o,
  input  logic                             wb_we_i,
  input  logic                             wb_stb_i,
  input  logic                             wb_cyc_i,
  output logic                             wb_ack_o,
  output logic                             wb_err_o,
  // DRP master side
  output logic [ADDR_WIDTH-1:0]            drp_addr,
  output logic [15:0]                      drp_do,
  input  logic [PORTS*16-1:0]              drp_di,
  output logic [PORTS-1:0]                 drp_en,
  output logic [PORTS-1:0]                 drp_we,
  input  logic [PORTS-1:0]                 drp_rdy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] sel_q;     // port of the transaction in flight
  logic                 we_q;      // transaction in flight is a write
  logic                 aborted;   // master dropped cyc while waiting
  logic [15:0]          cnt;       // timeout down-counter

  // Decode of the incoming request
  logic [SEL_WIDTH-1:0]  req_sel;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid;
  logic [PORTS-1:0]      req_onehot;

  // Read data and ready of the latched port
  logic [15:0]           sel_di;
  logic                  sel_rdy;
  logic                  abort_now;

  assign req_sel   = wb_adr_i[ADDR_WIDTH +: SEL_WIDTH];
  assign req_addr  = wb_adr_i[ADDR_WIDTH-1:0];
  assign req_valid = (32'(req_sel) < PORTS);
  // cyc can drop in the same cycle that the port completes.
  assign abort_now = aborted | ~wb_cyc_i;

  // Decode the requested port into a one-hot enable vector.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned. A missing default would infer a latch.
    req_onehot = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      req_onehot[p] = (32'(req_sel) == p);
    end
  end

  // Select the read data and ready of the port latched for this transaction.
  always_comb begin
    sel_di  = '0;
    sel_rdy = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (32'(sel_q) == p) begin
        sel_di  = drp_di[p*16 +: 16];
        sel_rdy = drp_rdy[p];
      end
    end
  end

  // Transaction FSM with all Wishbone and DRP outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only. Every
    // read in this block then sees the value from before the edge.
    if (rst) begin
      state    <= S_IDLE;
      sel_q    <= '0;
      we_q     <= 1'b0;
      aborted  <= 1'b0;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      drp_en   <= '0;
      drp_we   <= '0;
      drp_addr <= '0;
      drp_do   <= '0;
    end else begin
      // Responses and DRP strobes are single-cycle pulses by default.
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      drp_en   <= '0;
      drp_we   <= '0;

      case (state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (req_valid) begin
              sel_q    <= req_sel;
              we_q     <= wb_we_i;
              aborted  <= 1'b0;
              drp_addr <= req_addr;
              drp_do   <= wb_dat_i;
              drp_en   <= req_onehot;
              drp_we   <= wb_we_i ? req_onehot : '0;
              cnt      <= 16'(TIMEOUT);
              state    <= S_WAIT;
            end else begin
              // No port behind this select value, so refuse at once.
              wb_err_o <= 1'b1;
              state    <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          if (!wb_cyc_i) begin
            aborted <= 1'b1;
          end
          if (sel_rdy) begin
            // Ready wins over a timeout that expires in the same cycle.
            if (abort_now) begin
              state <= S_IDLE;
            end else begin
              if (!we_q) begin
                wb_dat_o <= sel_di;
              end
              wb_ack_o <= 1'b1;
              state    <= S_RESP;
            end
          end else if (TIMEOUT != 0) begin
            if (cnt == 16'd0) begin
              if (abort_now) begin
                state <= S_IDLE;
              end else begin
                wb_dat_o <= 16'hFFFF;
                wb_err_o <= 1'b1;
                state    <= S_RESP;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end

        S_RESP: begin
          // One response cycle. A strobe seen here is not a new request.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
